// File: rtl/bcd_to_bin.sv
// bcd_to_bin: packed multi-digit BCD to unsigned binary converter.
// Horner accumulation, one digit per clock, start/done handshake.
module bcd_to_bin #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                Clk,
    input  logic                nReset,
    input  logic                Start,
    input  logic [4*DIGITS-1:0] BcdIn,
    output logic                Busy,
    output logic                Done,
    output logic [BIN_W-1:0]    BinOut,
    output logic                Err
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DIGITS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [4*DIGITS-1:0] word;
    logic [BIN_W-1:0]    acc;
    logic [BIN_W-1:0]    acc10;
    logic [BIN_W-1:0]    acc_nxt;
    logic [IDX_W-1:0]    idx;
    logic                errf;
    logic                err_nxt;
    logic [3:0]          digit;
    logic                last;
    logic                accept;
    logic [3:0]          digs [DIGITS];

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        assign digs[g] = word[4*g +: 4];
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (Start) state_nxt = CONV;
            CONV:    if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Multiply by ten as shift-and-add; digit index walks MSD down to LSD.
    always_comb begin
        digit   = digs[idx];
        acc10   = (acc << 3) + (acc << 1);
        acc_nxt = acc10 + BIN_W'(digit);
        err_nxt = errf | (digit > 4'd9);
        last    = (idx == '0);
        accept  = (state == IDLE) && Start;
        Busy    = (state == CONV);
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            word   <= '0;
            acc    <= '0;
            idx    <= '0;
            errf   <= 1'b0;
            Done   <= 1'b0;
            BinOut <= '0;
            Err    <= 1'b0;
        end else begin
            Done <= (state == CONV) && last;
            if (accept) begin
                word <= BcdIn;
                acc  <= '0;
                idx  <= IDX_TOP;
                errf <= 1'b0;
            end else if (state == CONV) begin
                acc  <= acc_nxt;
                errf <= err_nxt;
                idx  <= idx - 1'b1;
                if (last) begin
                    BinOut <= err_nxt ? '0 : acc_nxt;
                    Err    <= err_nxt;
                end
            end
        end
    end

endmodule
